// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 architectural register file for the MIPS pipeline.
// It provides decode read ports with write-through bypass, a last-commit record, a commit counter and a debug port.
module wb_regfile #(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      y_mm_wb,
    input  logic [31:0]      data_mm_wb,
    input  logic [4:0]       dstn_mm_wb,
    input  logic             RegWrite_mm_wb,
    input  logic             MemtoReg_mm_wb,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    output logic [31:0]      rd_a,
    output logic [31:0]      rd_b,
    output logic [31:0]      wb_data,
    output logic             wb_we,
    output logic [4:0]       last_dstn,
    output logic [31:0]      last_data,
    output logic             last_vld,
    output logic [CNT_W-1:0] commit_cnt,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data
);

    logic [31:0]      regs_q [NREG];
    logic [31:0]      regs_d [NREG];
    logic [4:0]       last_dstn_q, last_dstn_d;
    logic [31:0]      last_data_q, last_data_d;
    logic             last_vld_q, last_vld_d;
    logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
    logic [31:0]      dbg_data_q, dbg_data_d;

    always_comb begin
        wb_data = MemtoReg_mm_wb ? data_mm_wb : y_mm_wb;
        wb_we   = RegWrite_mm_wb && (dstn_mm_wb != 5'd0);
    end

    // Register 0 never receives a write, so its entry stays at its reset value.
    always_comb begin
        if (rs_id == 5'd0)
            rd_a = '0;
        else if (wb_we && dstn_mm_wb == rs_id)
            rd_a = wb_data;
        else
            rd_a = regs_q[rs_id];

        if (rt_id == 5'd0)
            rd_b = '0;
        else if (wb_we && dstn_mm_wb == rt_id)
            rd_b = wb_data;
        else
            rd_b = regs_q[rt_id];
    end

    always_comb begin
        regs_d       = regs_q;
        last_dstn_d  = last_dstn_q;
        last_data_d  = last_data_q;
        last_vld_d   = wb_we;
        commit_cnt_d = commit_cnt_q;
        dbg_data_d   = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];
        if (wb_we) begin
            regs_d[dstn_mm_wb] = wb_data;
            last_dstn_d        = dstn_mm_wb;
            last_data_d        = wb_data;
            commit_cnt_d       = commit_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            last_dstn_q  <= '0;
            last_data_q  <= '0;
            last_vld_q   <= 1'b0;
            commit_cnt_q <= '0;
            dbg_data_q   <= '0;
        end else begin
            regs_q       <= regs_d;
            last_dstn_q  <= last_dstn_d;
            last_data_q  <= last_data_d;
            last_vld_q   <= last_vld_d;
            commit_cnt_q <= commit_cnt_d;
            dbg_data_q   <= dbg_data_d;
        end
    end

    assign last_dstn  = last_dstn_q;
    assign last_data  = last_data_q;
    assign last_vld   = last_vld_q;
    assign commit_cnt = commit_cnt_q;
    assign dbg_data   = dbg_data_q;

endmodule
